// File: rtl/touch_keypad_engine.sv
// Touch keypad front end: maps touch coordinates onto a key grid with gap
// rejection, debounces press and release, and emits press/repeat/release
// pulses plus a held level and the raw index of the last pressed key.
module touch_keypad_engine #(
  parameter int KP_X0        = 28,
  parameter int KP_Y0        = 30,
  parameter int KEY_W        = 60,
  parameter int KEY_H        = 45,
  parameter int GAP          = 8,
  parameter int NUM_COLS     = 4,
  parameter int NUM_ROWS     = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DLY   = 500,
  parameter int REPEAT_PER   = 100,
  localparam int KW = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          touch_valid,
  input  logic [9:0]    touch_x,
  input  logic [8:0]    touch_y,
  output logic          key_press,
  output logic          key_repeat,
  output logic          key_release,
  output logic          key_held,
  output logic [KW-1:0] key_index
);

  localparam int PITCH_X = KEY_W + GAP;
  localparam int PITCH_Y = KEY_H + GAP;
  localparam int DW      = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX    = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW      = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASING} state_t;

  state_t        state;
  logic          hit_c;
  logic [KW-1:0] hit_idx_c;
  logic          hit_p1;
  logic [KW-1:0] hit_idx_p1;
  logic [KW-1:0] cand;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  logic          rfirst;
  logic          match;
  logic          rep_due;
  logic [9:0]    x_rel, col_c, x_mod;
  logic [8:0]    y_rel, row_c, y_mod;
  logic [9:0]    idx_full;

  // Grid hit test: locate column/row by pitch division, reject gaps and off-grid
  always_comb begin
    x_rel    = touch_x - 10'(KP_X0);
    col_c    = x_rel / 10'(PITCH_X);
    x_mod    = x_rel % 10'(PITCH_X);
    y_rel    = touch_y - 9'(KP_Y0);
    row_c    = y_rel / 9'(PITCH_Y);
    y_mod    = y_rel % 9'(PITCH_Y);
    idx_full = 10'(row_c) * 10'(NUM_COLS) + col_c;
    hit_c    = touch_valid
             && (touch_x >= 10'(KP_X0)) && (col_c < 10'(NUM_COLS)) && (x_mod < 10'(KEY_W))
             && (touch_y >= 9'(KP_Y0))  && (row_c < 9'(NUM_ROWS))  && (y_mod < 9'(KEY_H));
    hit_idx_c = KW'(idx_full);
  end

  // ---- stage 1: registered hit sample ----
  // Hit flag is control state and is reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hit_p1 <= 1'b0;
    else          hit_p1 <= hit_c;
  end

  // Hit index is pure data; only meaningful alongside hit_p1
  always_ff @(posedge clk) begin
    hit_idx_p1 <= hit_idx_c;
  end

  // Candidate key tracks every sample while idle, freezing once debounce starts
  always_ff @(posedge clk) begin
    if (state == IDLE) cand <= hit_idx_p1;
  end

  assign match   = hit_p1 && (hit_idx_p1 == cand);
  assign rep_due = rfirst ? (rcnt == RW'(REPEAT_DLY - 1)) : (rcnt == RW'(REPEAT_PER - 1));

  // ---- stage 2: debounce/hold FSM with registered event outputs ----
  // Repeat counting advances only on matching held samples, so misses freeze it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dcnt        <= '0;
      rcnt        <= '0;
      rfirst      <= 1'b1;
      key_press   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      key_index   <= '0;
    end else begin
      key_press   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (hit_p1) begin
            if (DEBOUNCE_CYC == 1) begin
              state     <= HELD;
              key_press <= 1'b1;
              key_held  <= 1'b1;
              key_index <= hit_idx_p1;
              rcnt      <= '0;
              rfirst    <= 1'b1;
            end else begin
              state <= DEBOUNCE;
              dcnt  <= DW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= IDLE;
          end else if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
            state     <= HELD;
            key_press <= 1'b1;
            key_held  <= 1'b1;
            key_index <= cand;
            rcnt      <= '0;
            rfirst    <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        HELD: begin
          if (!match) begin
            if (DEBOUNCE_CYC == 1) begin
              state       <= IDLE;
              key_release <= 1'b1;
              key_held    <= 1'b0;
            end else begin
              state <= RELEASING;
              dcnt  <= DW'(1);
            end
          end else if (REPEAT_EN != 0) begin
            if (rep_due) begin
              key_repeat <= 1'b1;
              rcnt       <= '0;
              rfirst     <= 1'b0;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
        end
        RELEASING: begin
          if (match) begin
            state <= HELD;
            if (REPEAT_EN != 0) begin
              if (rep_due) begin
                key_repeat <= 1'b1;
                rcnt       <= '0;
                rfirst     <= 1'b0;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
          end else if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_held    <= 1'b0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_keypad_engine.sv
// Directed bench for touch_keypad_engine with short debounce and repeat timing.
module tb_touch_keypad_engine;

  logic       clk;
  logic       reset_n;
  logic       touch_valid;
  logic [9:0] touch_x;
  logic [8:0] touch_y;
  logic       key_press;
  logic       key_repeat;
  logic       key_release;
  logic       key_held;
  logic [3:0] key_index;

  int total;
  int bad;
  int cyc;
  int n_press, n_rep, n_rel, n_multi;
  int last_press, last_rel;
  int rep_t[64];

  touch_keypad_engine #(
    .DEBOUNCE_CYC(4),
    .REPEAT_EN   (1),
    .REPEAT_DLY  (20),
    .REPEAT_PER  (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .touch_valid(touch_valid),
    .touch_x    (touch_x),
    .touch_y    (touch_y),
    .key_press  (key_press),
    .key_repeat (key_repeat),
    .key_release(key_release),
    .key_held   (key_held),
    .key_index  (key_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value during cycle k is k
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (key_press) begin
      n_press    <= n_press + 1;
      last_press <= cyc;
    end
    if (key_repeat) begin
      if (n_rep < 64) rep_t[n_rep] <= cyc;
      n_rep <= n_rep + 1;
    end
    if (key_release) begin
      n_rel    <= n_rel + 1;
      last_rel <= cyc;
    end
    if (32'(key_press) + 32'(key_repeat) + 32'(key_release) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) cycles(1);
  endtask

  task automatic touch(input logic v, input int x, input int y);
    touch_valid = v;
    touch_x     = 10'(x);
    touch_y     = 9'(y);
  endtask

  int t0, p, bp, br, brep;

  initial begin
    total = 0; bad = 0; cyc = 0;
    n_press = 0; n_rep = 0; n_rel = 0; n_multi = 0;
    last_press = -1; last_rel = -1;
    reset_n = 1'b0;
    touch(1'b0, 0, 0);
    cycles(3);
    chk("rst_press",   32'(key_press),   0);
    chk("rst_repeat",  32'(key_repeat),  0);
    chk("rst_release", 32'(key_release), 0);
    chk("rst_held",    32'(key_held),    0);
    chk("rst_index",   32'(key_index),   0);
    reset_n = 1'b1;
    cycles(2);

    // Steady touch on index 9: press 5 cycles later
    t0 = cyc;
    touch(1'b1, 106, 146);
    cycles(8);
    chk("press_cnt",  n_press, 1);
    chk("press_lat",  last_press - t0, 5);
    chk("press_idx",  32'(key_index), 9);
    chk("press_held", 32'(key_held), 1);
    p = last_press;

    // Repeats at press+20/30/40/50
    wait_to(p + 55);
    chk("rep_cnt", n_rep, 4);
    chk("rep_1", rep_t[0] - p, 20);
    chk("rep_2", rep_t[1] - p, 30);
    chk("rep_3", rep_t[2] - p, 40);
    chk("rep_4", rep_t[3] - p, 50);

    // Lift: release 5 cycles later, no extra repeat
    t0 = cyc;
    touch(1'b0, 106, 146);
    cycles(10);
    chk("rel_cnt",  n_rel, 1);
    chk("rel_lat",  last_rel - t0, 5);
    chk("rel_held", 32'(key_held), 0);
    chk("rel_idx",  32'(key_index), 9);
    chk("rel_norep", n_rep, 4);

    // Gap and out-of-grid touches produce nothing
    bp = n_press; br = n_rel; brep = n_rep;
    touch(1'b1, 90, 146);
    cycles(50);
    touch(1'b1, 300, 50);
    cycles(50);
    touch(1'b0, 0, 0);
    cycles(5);
    chk("gap_press", n_press - bp, 0);
    chk("gap_rel",   n_rel - br, 0);
    chk("gap_rep",   n_rep - brep, 0);
    chk("gap_held",  32'(key_held), 0);

    // Short 3-cycle touch does not debounce
    touch(1'b1, 106, 146);
    cycles(3);
    touch(1'b0, 106, 146);
    cycles(10);
    chk("short_press", n_press - bp, 0);

    // Held with 2-cycle dropout: no release, repeats shift by 2
    t0 = cyc;
    touch(1'b1, 106, 146);
    cycles(8);
    chk("drop_press", n_press - bp, 1);
    p = last_press;
    brep = n_rep;
    wait_to(p + 15);
    touch(1'b0, 106, 146);
    cycles(2);
    touch(1'b1, 106, 146);
    wait_to(p + 35);
    chk("drop_norel", n_rel - br, 0);
    chk("drop_held",  32'(key_held), 1);
    chk("drop_repcnt", n_rep - brep, 2);
    chk("drop_rep1", rep_t[brep] - p, 22);
    chk("drop_rep2", rep_t[brep + 1] - p, 32);

    // Slide to key 0: release of 9, then fresh debounced press of 0
    t0 = cyc;
    touch(1'b1, 40, 40);
    cycles(12);
    chk("slide_rel",     n_rel - br, 1);
    chk("slide_rel_lat", last_rel - t0, 5);
    chk("slide_press",   n_press - bp, 2);
    chk("slide_prs_lat", last_press - t0, 9);
    chk("slide_idx",     32'(key_index), 0);
    chk("slide_held",    32'(key_held), 1);

    // Reset while held: outputs clear at once, no release afterwards
    br = n_rel;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_held",  32'(key_held), 0);
    chk("mid_rst_index", 32'(key_index), 0);
    chk("mid_rst_press", 32'(key_press), 0);
    touch(1'b0, 40, 40);
    cycles(2);
    reset_n = 1'b1;
    cycles(12);
    chk("mid_rst_norel", n_rel - br, 0);
    chk("mid_rst_held2", 32'(key_held), 0);

    chk("one_hot_events", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
